// File: rtl/semaphore_pkg.sv
// Shared definitions for the semaphore lock protocol: client state encoding,
// default sizing, and a grant-bus sanity helper used by requester and arbiter.
package semaphore_pkg;

  localparam int NUM_CLIENTS_DEF = 8;
  localparam int HOLD_MAX_DEF    = 15;
  localparam int CNT_W_DEF       = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2,
    ST_REL  = 2'd3
  } client_state_e;

  // True when at most one bit is set; callers zero-extend buses of up to 32 clients.
  function automatic logic is_onehot0(input logic [31:0] v);
    return ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/semaphore_client_fsm.sv
// One client's view of the lock: request/wait/hold/release sequencing plus the
// hold-time counter that forces a release when a critical section overruns.
module semaphore_client_fsm
  import semaphore_pkg::*;
#(
  parameter int HOLD_MAX = HOLD_MAX_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic want,
  input  logic done,
  input  logic grant,
  output logic req,
  output logic rel,
  output logic owns,
  output logic timeout,
  output logic fault
);

  client_state_e    state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             cancel_r, cancel_s;
  logic             req_r, req_s;
  logic             rel_r, rel_s;
  logic             owns_r, owns_s;
  logic             tout_r, tout_s;
  logic             fault_s;

  // State, counter and registered client outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      cnt_r    <= '0;
      cancel_r <= 1'b0;
      req_r    <= 1'b0;
      rel_r    <= 1'b0;
      owns_r   <= 1'b0;
      tout_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      cancel_r <= cancel_s;
      req_r    <= req_s;
      rel_r    <= rel_s;
      owns_r   <= owns_s;
      tout_r   <= tout_s;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    cancel_s = cancel_r;
    req_s    = 1'b0;
    rel_s    = 1'b0;
    owns_s   = owns_r;
    tout_s   = 1'b0;
    fault_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        fault_s = grant;
        if (want) begin
          req_s    = 1'b1;
          cancel_s = 1'b0;
          state_s  = ST_WAIT;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // A request already queued cannot be withdrawn, so a cancelled client
        // still takes its grant and hands it straight back.
        if (grant) begin
          cancel_s = 1'b0;
          if (cancel_r || !want) begin
            rel_s   = 1'b1;
            owns_s  = 1'b0;
            state_s = ST_REL;
          end else begin
            owns_s  = 1'b1;
            cnt_s   = '0;
            state_s = ST_HOLD;
          end
        end else begin
          cancel_s = cancel_r | ~want;
        end
      end
      ST_HOLD: begin
        if (!grant) begin
          fault_s = 1'b1;
          owns_s  = 1'b0;
          state_s = ST_IDLE;
        end else if (done) begin
          rel_s   = 1'b1;
          owns_s  = 1'b0;
          state_s = ST_REL;
        end else if (cnt_r == CNT_W'(HOLD_MAX)) begin
          rel_s   = 1'b1;
          tout_s  = 1'b1;
          owns_s  = 1'b0;
          state_s = ST_REL;
        end else begin
          cnt_s   = cnt_r + CNT_W'(1);
        end
      end
      ST_REL: begin
        owns_s = 1'b0;
        if (!grant) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_REL;
        end
      end
      default: begin
        owns_s  = 1'b0;
        state_s = ST_IDLE;
      end
    endcase
  end

  assign req     = req_r;
  assign rel     = rel_r;
  assign owns    = owns_r;
  assign timeout = tout_r;
  assign fault   = fault_s;

endmodule

// File: rtl/semaphore_requester.sv
// Client-side end of the semaphore lock protocol: one FSM per client slot plus
// grant-bus checking folded into a sticky protocol error flag.
module semaphore_requester
  import semaphore_pkg::*;
#(
  parameter int NUM_CLIENTS = NUM_CLIENTS_DEF,
  parameter int HOLD_MAX    = HOLD_MAX_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_CLIENTS-1:0] want_i,
  input  logic [NUM_CLIENTS-1:0] done_i,
  input  logic [NUM_CLIENTS-1:0] grant_i,
  output logic [NUM_CLIENTS-1:0] req_o,
  output logic [NUM_CLIENTS-1:0] release_o,
  output logic [NUM_CLIENTS-1:0] owns_o,
  output logic [NUM_CLIENTS-1:0] timeout_o,
  output logic                   err_o
);

  logic [NUM_CLIENTS-1:0] fault_s;
  logic                   grant_bad_s;
  logic                   err_r;

  for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_client
    semaphore_client_fsm #(
      .HOLD_MAX (HOLD_MAX),
      .CNT_W    (CNT_W)
    ) u_fsm (
      .clk     (clk),
      .rst_n   (rst_n),
      .want    (want_i[gi]),
      .done    (done_i[gi]),
      .grant   (grant_i[gi]),
      .req     (req_o[gi]),
      .rel     (release_o[gi]),
      .owns    (owns_o[gi]),
      .timeout (timeout_o[gi]),
      .fault   (fault_s[gi])
    );
  end

  // Grant bus must be idle or name exactly one owner.
  always_comb begin
    grant_bad_s = !is_onehot0(32'(grant_i));
  end

  // Sticky protocol error, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r | grant_bad_s | (|fault_s);
    end
  end

  assign err_o = err_r;

endmodule

// File: tb/tb_semaphore_requester.sv
// Directed protocol scenarios followed by a randomized run against a behavioural
// client model, with the bench itself acting as a FCFS lock arbiter.
module tb_semaphore_requester;
  import semaphore_pkg::*;

  localparam int N = NUM_CLIENTS_DEF;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] want, done, grant;
  logic [N-1:0] req_o, release_o, owns_o, timeout_o;
  logic         err_o;

  int tests  = 0;
  int failed = 0;

  // Reference model state
  logic [N-1:0] m_queued, m_cancel, m_hold, m_ret;
  int           m_held [N];
  logic         m_err;
  logic [N-1:0] e_req, e_rel, e_tout, e_owns;
  int           arb_q [$];
  int           owner;

  semaphore_requester dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .want_i    (want),
    .done_i    (done),
    .grant_i   (grant),
    .req_o     (req_o),
    .release_o (release_o),
    .owns_o    (owns_o),
    .timeout_o (timeout_o),
    .err_o     (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_queued = '0; m_cancel = '0; m_hold = '0; m_ret = '0; m_err = 1'b0;
    for (int i = 0; i < N; i++) m_held[i] = 0;
    arb_q.delete();
    owner = -1;
  endtask

  // One clock of the client protocol as described in words: inputs seen during the
  // cycle, expected registered outputs after the edge.
  task automatic model_step(input logic [N-1:0] w, input logic [N-1:0] d, input logic [N-1:0] g);
    e_req = '0; e_rel = '0; e_tout = '0;
    if ($countones(g) > 1) m_err = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (m_hold[i]) begin
        if (!g[i]) begin
          m_err = 1'b1; m_hold[i] = 1'b0;
        end else if (d[i]) begin
          m_hold[i] = 1'b0; m_ret[i] = 1'b1; e_rel[i] = 1'b1;
        end else if (m_held[i] == HOLD_MAX_DEF) begin
          m_hold[i] = 1'b0; m_ret[i] = 1'b1; e_rel[i] = 1'b1; e_tout[i] = 1'b1;
        end else begin
          m_held[i]++;
        end
      end else if (m_queued[i]) begin
        if (g[i]) begin
          m_queued[i] = 1'b0;
          if (m_cancel[i] || !w[i]) begin
            m_ret[i] = 1'b1; e_rel[i] = 1'b1;
          end else begin
            m_hold[i] = 1'b1; m_held[i] = 0;
          end
        end else if (!w[i]) begin
          m_cancel[i] = 1'b1;
        end
      end else if (m_ret[i]) begin
        if (!g[i]) m_ret[i] = 1'b0;
      end else begin
        if (g[i]) m_err = 1'b1;
        if (w[i]) begin
          m_queued[i] = 1'b1; m_cancel[i] = 1'b0; e_req[i] = 1'b1;
        end
      end
    end
    e_owns = m_hold;
  endtask

  initial begin
    rst_n = 1'b0; want = '0; done = '0; grant = '0;
    tick(); tick();
    chk("rst_req", req_o, 0);
    chk("rst_rel", release_o, 0);
    chk("rst_owns", owns_o, 0);
    chk("rst_tout", timeout_o, 0);
    chk("rst_err", err_o, 0);
    rst_n = 1'b1;

    // Basic request / grant / done / release
    want = 8'h04; tick();
    chk("basic_req", req_o, 8'h04);
    tick();
    chk("basic_req_pulse", req_o, 8'h00);
    grant = 8'h04; tick();
    chk("basic_owns", owns_o, 8'h04);
    done = 8'h04; tick();
    chk("basic_rel", release_o, 8'h04);
    chk("basic_owns_fall", owns_o, 8'h00);
    done = '0; want = '0; grant = '0; tick();
    chk("basic_rel_pulse", release_o, 8'h00);
    tick();
    chk("basic_idle_req", req_o, 8'h00);
    chk("basic_err", err_o, 1'b0);

    // Timeout after HOLD_MAX
    want = 8'h01; tick();
    chk("to_req", req_o, 8'h01);
    grant = 8'h01; tick();
    chk("to_owns", owns_o, 8'h01);
    for (int k = 1; k <= HOLD_MAX_DEF; k++) begin
      tick();
      chk("to_hold_owns", owns_o, 8'h01);
      chk("to_hold_tout", timeout_o, 8'h00);
    end
    tick();
    chk("to_tout", timeout_o, 8'h01);
    chk("to_rel", release_o, 8'h01);
    chk("to_owns_fall", owns_o, 8'h00);
    want = '0; grant = '0; tick();
    chk("to_tout_pulse", timeout_o, 8'h00);

    // done and timeout in the same cycle: done wins
    want = 8'h01; tick();
    grant = 8'h01; tick();
    for (int k = 1; k <= HOLD_MAX_DEF; k++) tick();
    chk("tie_owns", owns_o, 8'h01);
    done = 8'h01; tick();
    chk("tie_rel", release_o, 8'h01);
    chk("tie_tout", timeout_o, 8'h00);
    done = '0; want = '0; grant = '0; tick();

    // Cancelled request returns the lock immediately
    want = 8'h20; tick();
    chk("cancel_req", req_o, 8'h20);
    want = '0; tick(); tick();
    grant = 8'h20; tick();
    chk("cancel_rel", release_o, 8'h20);
    chk("cancel_owns", owns_o, 8'h00);
    grant = '0; tick();
    chk("cancel_owns2", owns_o, 8'h00);
    chk("cancel_err", err_o, 1'b0);

    // Reset while holding
    want = 8'h08; tick();
    grant = 8'h08; tick();
    chk("rsthold_owns", owns_o, 8'h08);
    want = '0; rst_n = 1'b0; tick();
    chk("rsthold_owns0", owns_o, 8'h00);
    chk("rsthold_rel0", release_o, 8'h00);
    rst_n = 1'b1; grant = '0; tick();
    chk("rsthold_rel_after", release_o, 8'h00);
    chk("rsthold_err", err_o, 1'b0);

    // Errors
    grant = 8'h03; tick();
    chk("err_multi", err_o, 1'b1);
    grant = '0; tick(); tick();
    chk("err_sticky", err_o, 1'b1);
    rst_n = 1'b0; tick();
    chk("err_rst", err_o, 1'b0);
    rst_n = 1'b1; tick();
    grant = 8'h80; tick();
    chk("err_idle_grant", err_o, 1'b1);
    grant = '0; rst_n = 1'b0; tick();
    rst_n = 1'b1;

    // Randomized run with bench as FCFS arbiter
    model_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(7) == 0) want[i] = ~want[i];
        done[i] = ($urandom_range(15) == 0);
      end
      grant = (owner >= 0) ? (N'(1) << owner) : '0;
      model_step(want, done, grant);
      tick();
      chk("rnd_req", req_o, e_req);
      chk("rnd_rel", release_o, e_rel);
      chk("rnd_owns", owns_o, e_owns);
      chk("rnd_tout", timeout_o, e_tout);
      chk("rnd_err", err_o, m_err);
      for (int i = 0; i < N; i++) if (e_req[i]) arb_q.push_back(i);
      if (owner >= 0 && e_rel[owner]) owner = -1;
      if (owner < 0 && arb_q.size() > 0) owner = arb_q.pop_front();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
